trig_capture_ctrl: RTL and testbench

TRIG_CAPTURE_CTRL -- requirements
Module: trig_capture_ctrl

---
 rtl/trig_capture_ctrl.sv | 159 +++++++++++++++
 tb/tb_trig_capture_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_capture_ctrl.sv
// Trigger/capture controller for a circular sample RAM: fills pre-trigger history,
// arms the channel trigger stages, then collects trig_pos post-trigger samples.
module trig_capture_ctrl #(
    parameter int DEPTH = 384,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CH1Trig,
    input  logic          CH2Trig,
    input  logic          CH3Trig,
    input  logic          CH4Trig,
    input  logic          CH5Trig,
    input  logic          protTrig,
    input  logic          start,
    input  logic          clr_done,
    input  logic          smpl,
    input  logic [AW-1:0] trig_pos,
    output logic          armed,
    output logic          triggered,
    output logic          capture_done,
    output logic          we,
    output logic [AW-1:0] waddr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q;
    logic          trig_ff_q;
    logic          armed_q;
    logic          triggered_q;
    logic          done_q;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] fill_cnt_q;
    logic [AW-1:0] post_cnt_q;
    logic [AW-1:0] trig_pos_q;

    logic          trig_all_s;
    logic          capturing_s;
    logic          we_s;
    logic [AW:0]   fill_inc_s;
    logic [AW:0]   post_inc_s;
    logic [AW:0]   fill_thr_s;
    logic [AW-1:0] waddr_inc_s;

    // Combined trigger, write strobe and counter increments; thresholds use one extra bit
    // so a full-depth pre-trigger fill (trig_pos = 0) is representable.
    always_comb begin
        trig_all_s  = CH1Trig & CH2Trig & CH3Trig & CH4Trig & CH5Trig & protTrig;
        capturing_s = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
        we_s        = smpl & capturing_s;
        fill_inc_s  = {1'b0, fill_cnt_q} + (AW+1)'(1);
        post_inc_s  = {1'b0, post_cnt_q} + (AW+1)'(1);
        fill_thr_s  = DEPTH_W - {1'b0, trig_pos_q};
        if (waddr_q == LAST_ADDR) begin
            waddr_inc_s = {AW{1'b0}};
        end else begin
            waddr_inc_s = waddr_q + AW'(1);
        end
    end

    // Capture FSM with registered status outputs, write pointer and sample counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            trig_ff_q   <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            waddr_q     <= {AW{1'b0}};
            fill_cnt_q  <= {AW{1'b0}};
            post_cnt_q  <= {AW{1'b0}};
            trig_pos_q  <= {AW{1'b0}};
        end else begin
            trig_ff_q <= trig_all_s;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FILL;
                        waddr_q    <= {AW{1'b0}};
                        fill_cnt_q <= {AW{1'b0}};
                        post_cnt_q <= {AW{1'b0}};
                        trig_pos_q <= trig_pos;
                    end
                end
                FILL: begin
                    if (we_s) begin
                        waddr_q <= waddr_inc_s;
                        if (fill_inc_s == fill_thr_s) begin
                            state_q    <= ARMED;
                            armed_q    <= 1'b1;
                            fill_cnt_q <= {AW{1'b0}};
                        end else begin
                            fill_cnt_q <= fill_inc_s[AW-1:0];
                        end
                    end
                end
                ARMED: begin
                    // A write on the accepting edge still belongs to the pre-trigger history.
                    if (we_s) begin
                        waddr_q <= waddr_inc_s;
                    end
                    if (trig_ff_q) begin
                        armed_q     <= 1'b0;
                        triggered_q <= 1'b1;
                        post_cnt_q  <= {AW{1'b0}};
                        if (trig_pos_q == {AW{1'b0}}) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= POST;
                        end
                    end
                end
                POST: begin
                    if (we_s) begin
                        waddr_q <= waddr_inc_s;
                        if (post_inc_s == {1'b0, trig_pos_q}) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            post_cnt_q <= {AW{1'b0}};
                        end else begin
                            post_cnt_q <= post_inc_s[AW-1:0];
                        end
                    end
                end
                DONE: begin
                    if (clr_done) begin
                        state_q     <= IDLE;
                        triggered_q <= 1'b0;
                        done_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    armed_q     <= 1'b0;
                    triggered_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign armed        = armed_q;
    assign triggered    = triggered_q;
    assign capture_done = done_q;
    assign we           = we_s;
    assign waddr        = waddr_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed self-checking bench for trig_capture_ctrl (DEPTH=384, AW=9).
module tb_trig_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       CH1Trig, CH2Trig, CH3Trig, CH4Trig, CH5Trig, protTrig;
    logic       start, clr_done, smpl;
    logic [8:0] trig_pos;
    logic       armed, triggered, capture_done, we;
    logic [8:0] waddr;

    int tests_run    = 0;
    int tests_failed = 0;

    trig_capture_ctrl #(.DEPTH(384), .AW(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .CH1Trig(CH1Trig), .CH2Trig(CH2Trig), .CH3Trig(CH3Trig),
        .CH4Trig(CH4Trig), .CH5Trig(CH5Trig), .protTrig(protTrig),
        .start(start), .clr_done(clr_done), .smpl(smpl), .trig_pos(trig_pos),
        .armed(armed), .triggered(triggered), .capture_done(capture_done),
        .we(we), .waddr(waddr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_trig(input logic v);
        CH1Trig = v; CH2Trig = v; CH3Trig = v; CH4Trig = v; CH5Trig = v; protTrig = v;
    endtask

    task automatic pulse_smpl(input int n);
        smpl = 1'b1;
        repeat (n) tick();
        smpl = 1'b0;
    endtask

    task automatic do_start(input logic [8:0] tp);
        trig_pos = tp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fire_trigger();
        set_trig(1'b1);
        tick();
        set_trig(1'b0);
        tick();
    endtask

    task automatic do_clear();
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_trig(1'b0);
        start = 1'b0; clr_done = 1'b0; smpl = 1'b1; trig_pos = 9'd128;
        tick(); tick();
        tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL reset_armed: got %b want 0", armed); end
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL reset_triggered: got %b want 0", triggered); end
        tests_run++; if (capture_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", capture_done); end
        tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", we); end
        tests_run++; if (waddr !== 9'd0) begin tests_failed++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        smpl = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        do_start(9'd128);
        smpl = 1'b1; #1;
        tests_run++; if (we !== 1'b1) begin tests_failed++; $display("FAIL normal_we_fill: got %b want 1", we); end
        smpl = 1'b0; #1;
        pulse_smpl(255);
        tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL normal_armed_early: got %b want 0", armed); end
        pulse_smpl(1);
        tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL normal_armed: got %b want 1", armed); end
        tests_run++; if (waddr !== 9'd256) begin tests_failed++; $display("FAIL normal_waddr_armed: got %0d want 256", waddr); end
        set_trig(1'b1);
        tick();
        set_trig(1'b0);
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL normal_trig_latency: got %b want 0", triggered); end
        tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL normal_armed_latency: got %b want 1", armed); end
        tick();
        tests_run++; if (triggered !== 1'b1) begin tests_failed++; $display("FAIL normal_triggered: got %b want 1", triggered); end
        tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL normal_armed_drop: got %b want 0", armed); end
        trig_pos = 9'd5;
        pulse_smpl(127);
        tests_run++; if (capture_done !== 1'b0) begin tests_failed++; $display("FAIL normal_done_early: got %b want 0", capture_done); end
        pulse_smpl(1);
        tests_run++; if (capture_done !== 1'b1) begin tests_failed++; $display("FAIL normal_done: got %b want 1", capture_done); end
        tests_run++; if (waddr !== 9'd0) begin tests_failed++; $display("FAIL normal_waddr_done: got %0d want 0", waddr); end
        smpl = 1'b1; #1;
        tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL normal_we_done: got %b want 0", we); end
        tick(); smpl = 1'b0;
        tests_run++; if (waddr !== 9'd0) begin tests_failed++; $display("FAIL normal_waddr_frozen: got %0d want 0", waddr); end
        start = 1'b1; tick(); start = 1'b0;
        tests_run++; if (capture_done !== 1'b1) begin tests_failed++; $display("FAIL normal_start_in_done: got %b want 1", capture_done); end
        do_clear();
        tests_run++; if (capture_done !== 1'b0 || triggered !== 1'b0) begin tests_failed++; $display("FAIL normal_clear: got done=%b trig=%b want 0 0", capture_done, triggered); end
    endtask

    task automatic test_wrap();
        do_start(9'd128);
        pulse_smpl(256);
        pulse_smpl(200);
        tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL wrap_armed: got %b want 1", armed); end
        tests_run++; if (waddr !== 9'd72) begin tests_failed++; $display("FAIL wrap_waddr_armed: got %0d want 72", waddr); end
        fire_trigger();
        tests_run++; if (triggered !== 1'b1) begin tests_failed++; $display("FAIL wrap_triggered: got %b want 1", triggered); end
        pulse_smpl(128);
        tests_run++; if (capture_done !== 1'b1) begin tests_failed++; $display("FAIL wrap_done: got %b want 1", capture_done); end
        tests_run++; if (waddr !== 9'd200) begin tests_failed++; $display("FAIL wrap_waddr_done: got %0d want 200", waddr); end
        do_clear();
    endtask

    task automatic test_early_trigger();
        do_start(9'd300);
        set_trig(1'b1);
        pulse_smpl(83);
        tests_run++; if (armed !== 1'b0 || triggered !== 1'b0) begin tests_failed++; $display("FAIL early_fill: got armed=%b trig=%b want 0 0", armed, triggered); end
        pulse_smpl(1);
        tests_run++; if (armed !== 1'b1 || triggered !== 1'b0) begin tests_failed++; $display("FAIL early_armed: got armed=%b trig=%b want 1 0", armed, triggered); end
        tick();
        set_trig(1'b0);
        tests_run++; if (armed !== 1'b0 || triggered !== 1'b1) begin tests_failed++; $display("FAIL early_accept: got armed=%b trig=%b want 0 1", armed, triggered); end
        tests_run++; if (waddr !== 9'd84) begin tests_failed++; $display("FAIL early_waddr: got %0d want 84", waddr); end
        pulse_smpl(299);
        tests_run++; if (capture_done !== 1'b0) begin tests_failed++; $display("FAIL early_done_early: got %b want 0", capture_done); end
        pulse_smpl(1);
        tests_run++; if (capture_done !== 1'b1 || waddr !== 9'd0) begin tests_failed++; $display("FAIL early_done: got done=%b waddr=%0d want 1 0", capture_done, waddr); end
        do_clear();
    endtask

    task automatic test_partial();
        do_start(9'd128);
        pulse_smpl(256);
        set_trig(1'b1);
        CH3Trig = 1'b0;
        repeat (20) tick();
        pulse_smpl(10);
        tests_run++; if (armed !== 1'b1 || triggered !== 1'b0) begin tests_failed++; $display("FAIL partial_hold: got armed=%b trig=%b want 1 0", armed, triggered); end
        tests_run++; if (waddr !== 9'd266) begin tests_failed++; $display("FAIL partial_waddr: got %0d want 266", waddr); end
        set_trig(1'b0);
        fire_trigger();
        tests_run++; if (triggered !== 1'b1) begin tests_failed++; $display("FAIL partial_triggered: got %b want 1", triggered); end
        pulse_smpl(128);
        tests_run++; if (capture_done !== 1'b1 || waddr !== 9'd10) begin tests_failed++; $display("FAIL partial_done: got done=%b waddr=%0d want 1 10", capture_done, waddr); end
        do_clear();
    endtask

    task automatic test_trigpos0();
        do_start(9'd0);
        pulse_smpl(383);
        tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL tp0_armed_early: got %b want 0", armed); end
        pulse_smpl(1);
        tests_run++; if (armed !== 1'b1 || waddr !== 9'd0) begin tests_failed++; $display("FAIL tp0_armed: got armed=%b waddr=%0d want 1 0", armed, waddr); end
        set_trig(1'b1);
        tick();
        set_trig(1'b0);
        tests_run++; if (triggered !== 1'b0) begin tests_failed++; $display("FAIL tp0_latency: got %b want 0", triggered); end
        tick();
        tests_run++; if (triggered !== 1'b1 || capture_done !== 1'b1 || armed !== 1'b0) begin tests_failed++; $display("FAIL tp0_done: got trig=%b done=%b armed=%b want 1 1 0", triggered, capture_done, armed); end
        smpl = 1'b1; #1;
        tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL tp0_we: got %b want 0", we); end
        tick(); tick(); smpl = 1'b0;
        tests_run++; if (waddr !== 9'd0) begin tests_failed++; $display("FAIL tp0_waddr: got %0d want 0", waddr); end
        do_clear();
    endtask

    task automatic test_reset_midpost();
        do_start(9'd128);
        pulse_smpl(256);
        fire_trigger();
        pulse_smpl(50);
        tests_run++; if (triggered !== 1'b1 || capture_done !== 1'b0 || waddr !== 9'd306) begin tests_failed++; $display("FAIL midpost_state: got trig=%b done=%b waddr=%0d want 1 0 306", triggered, capture_done, waddr); end
        #2; rst_n = 1'b0; smpl = 1'b1; #1;
        tests_run++; if (armed !== 1'b0 || triggered !== 1'b0 || capture_done !== 1'b0) begin tests_failed++; $display("FAIL midpost_async: got armed=%b trig=%b done=%b want 0 0 0", armed, triggered, capture_done); end
        tests_run++; if (we !== 1'b0 || waddr !== 9'd0) begin tests_failed++; $display("FAIL midpost_async_wr: got we=%b waddr=%0d want 0 0", we, waddr); end
        tick();
        smpl = 1'b0; rst_n = 1'b1;
        do_start(9'd128);
        smpl = 1'b1; #1;
        tests_run++; if (we !== 1'b1) begin tests_failed++; $display("FAIL first_start: got we=%b want 1", we); end
        pulse_smpl(256);
        fire_trigger();
        pulse_smpl(128);
        tests_run++; if (capture_done !== 1'b1) begin tests_failed++; $display("FAIL second_done: got %b want 1", capture_done); end
        start = 1'b1; clr_done = 1'b1;
        tick();
        start = 1'b0; clr_done = 1'b0;
        tests_run++; if (capture_done !== 1'b0 || triggered !== 1'b0) begin tests_failed++; $display("FAIL simul_clear: got done=%b trig=%b want 0 0", capture_done, triggered); end
        smpl = 1'b1; #1;
        tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL simul_start_dropped: got we=%b want 0", we); end
        tick(); smpl = 1'b0;
        tests_run++; if (waddr !== 9'd0 || armed !== 1'b0) begin tests_failed++; $display("FAIL simul_idle: got waddr=%0d armed=%b want 0 0", waddr, armed); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_wrap();
        test_early_trigger();
        test_partial();
        test_trigpos0();
        test_reset_midpost();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
